// File: rtl/sa_drain_pkg.sv
// Shared parameters, FSM state type and beat-to-row mapping for the systolic-array result drain.
// Contents:
//   DW, ROWS, COLS, AW  word width, tile rows (beats), tile columns (words per beat), read addr width
//   WORDS, RW           derived tile size and row-index width
//   state_t             drain FSM states S_IDLE / S_CAPTURE / S_DONE
//   row_of_beat()       the array emits its bottom row first, so beat k lands in row ROWS-1-k
package sa_drain_pkg;

   localparam int unsigned DW    = 32;
   localparam int unsigned ROWS  = 5;
   localparam int unsigned COLS  = 5;
   localparam int unsigned AW    = 5;
   localparam int unsigned WORDS = ROWS * COLS;
   localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_CAPTURE = 2'b01,
      S_DONE    = 2'b10
   } state_t;

   function automatic logic [RW-1:0] row_of_beat(input logic [RW-1:0] k);
      return RW'(ROWS - 1) - k;
   endfunction

endpackage

// File: rtl/sa_result_drain_if.sv
// Bundle of capture, acknowledge and read signals between the array/host side and the drain.
// Signals:
//   cap_valid  beat strobe (array wr_en)          col_in    COLS*DW beat data, col c at [c*DW +: DW]
//   ack        releases a finished tile           rd_addr   read address = row*COLS + col
//   rd_data    registered read data               done      full tile held
//   ovf        sticky overflow flag               tile_cnt  completed tile counter
//   acc_en     per-beat accumulate select (only with RESULT_DRAIN_ACCUM_EN defined)
// Modports: master = array/host side, slave = sa_result_drain.
interface sa_result_drain_if;
   import sa_drain_pkg::*;

   logic               cap_valid;
   logic [COLS*DW-1:0] col_in;
   logic               ack;
   logic [AW-1:0]      rd_addr;
   logic [DW-1:0]      rd_data;
   logic               done;
   logic               ovf;
   logic [7:0]         tile_cnt;
`ifdef RESULT_DRAIN_ACCUM_EN
   logic               acc_en;
`endif

   modport master (
`ifdef RESULT_DRAIN_ACCUM_EN
      output acc_en,
`endif
      output cap_valid, col_in, ack, rd_addr,
      input  rd_data, done, ovf, tile_cnt
   );

   modport slave (
`ifdef RESULT_DRAIN_ACCUM_EN
      input  acc_en,
`endif
      input  cap_valid, col_in, ack, rd_addr,
      output rd_data, done, ovf, tile_cnt
   );

endinterface

// File: rtl/sa_result_bank.sv
// ROWS*COLS x DW result register array with a row-wide write port and one registered read port.
// Ports:
//   clk, rst   clock and synchronous active-low reset (reset clears rd_data only, not the array)
//   wr_en      write the row selected by wr_row
//   wr_row     destination row index
//   wr_data    COLS words, word c at [c*DW +: DW]
//   wr_acc     1: add wr_data to the stored words (mod 2^DW), 0: overwrite
//   rd_addr    read address, row-major; addresses >= ROWS*COLS read as 0
//   rd_data    registered read data; a same-cycle write to rd_addr yields the old word
module sa_result_bank
   import sa_drain_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [RW-1:0]      wr_row,
   input  logic [COLS*DW-1:0] wr_data,
   input  logic               wr_acc,
   input  logic [AW-1:0]      rd_addr,
   output logic [DW-1:0]      rd_data
);

   logic [DW-1:0] mem_q [WORDS];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int r = 0; r < ROWS; r++) begin
            if (wr_row == RW'(r)) begin
               for (int c = 0; c < COLS; c++) begin
                  if (wr_acc) begin
                     mem_q[r*COLS + c] <= mem_q[r*COLS + c] + wr_data[c*DW +: DW];
                  end else begin
                     mem_q[r*COLS + c] <= wr_data[c*DW +: DW];
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_data <= '0;
      end else if (rd_addr < AW'(WORDS)) begin
         rd_data <= mem_q[rd_addr];
      end else begin
         rd_data <= '0;
      end
   end

endmodule

// File: rtl/sa_result_drain.sv
// Result drain stage of the systolic array: captures ROWS beats of COLS words shifted out of the
// bottom PE layer into a row-major result tile, flags done, and serves reads until acknowledged.
// Ports:
//   clk   single clock, all logic on posedge
//   rst   synchronous active-low reset
//   bus   sa_result_drain_if.slave (cap_valid, col_in, ack, rd_addr, rd_data, done, ovf, tile_cnt)
// Optional feature: define RESULT_DRAIN_ACCUM_EN to add bus.acc_en, which makes a beat add into
// the stored row instead of overwriting it (K-tiling across passes).
module sa_result_drain
   import sa_drain_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   sa_result_drain_if.slave bus
);

   state_t        state_q;
   logic [RW-1:0] beat_cnt_q;
   logic          done_q;
   logic          ovf_q;
   logic [7:0]    tile_cnt_q;

   logic          in_done;
   logic          accept;
   logic          last_beat;
   logic          wr_acc;

   assign in_done   = (state_q == S_DONE);
   // A finished tile only takes a new beat in the same cycle it is released.
   assign accept    = bus.cap_valid && (!in_done || bus.ack);
   // beat_cnt_q is 0 in IDLE and DONE, so a beat accepted there is beat 0.
   assign last_beat = (beat_cnt_q == RW'(ROWS - 1));

`ifdef RESULT_DRAIN_ACCUM_EN
   assign wr_acc = bus.acc_en;
`else
   assign wr_acc = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         beat_cnt_q <= '0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
         tile_cnt_q <= '0;
      end else begin
         if (accept) begin
            if (last_beat) begin
               state_q    <= S_DONE;
               done_q     <= 1'b1;
               tile_cnt_q <= tile_cnt_q + 8'd1;
               beat_cnt_q <= '0;
            end else begin
               state_q    <= S_CAPTURE;
               done_q     <= 1'b0;
               beat_cnt_q <= beat_cnt_q + RW'(1);
            end
         end else if (in_done && bus.ack) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
         end

         if (in_done && !bus.ack && bus.cap_valid) begin
            ovf_q <= 1'b1;
         end
      end
   end

   assign bus.done     = done_q;
   assign bus.ovf      = ovf_q;
   assign bus.tile_cnt = tile_cnt_q;

   sa_result_bank u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (accept),
      .wr_row  (row_of_beat(beat_cnt_q)),
      .wr_data (bus.col_in),
      .wr_acc  (wr_acc),
      .rd_addr (bus.rd_addr),
      .rd_data (bus.rd_data)
   );

endmodule
